// File: rtl/nac_axi_port_arbiter.sv
// nac_axi_port_arbiter: round-robin sharing of one NAC AXI adapter sys_* port among NUM_REQ requesters.
// Optional stall watchdog (WDOG_CYCLES, wdog_clr, wdog_timeout) enabled by defining NAC_ARB_WDOG_EN.
module nac_axi_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
`ifdef NAC_ARB_WDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                           M_AXI_ACLK,
  input  logic                           M_AXI_ARESETN,
`ifdef NAC_ARB_WDOG_EN
  input  logic                           wdog_clr,
  output logic                           wdog_timeout,
`endif
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]             req_wvalid,
  output logic [NUM_REQ-1:0]             req_wready,
  output logic [NUM_REQ-1:0]             req_accept,
  output logic [NUM_REQ-1:0]             req_rvalid,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic [NUM_REQ-1:0]             req_done,
  output logic [NUM_REQ-1:0]             req_error,
  output logic [ADDR_WIDTH-1:0]          sys_addr,
  output logic [LEN_WIDTH-1:0]           sys_len,
  output logic                           sys_req,
  output logic                           sys_we,
  output logic [DATA_WIDTH-1:0]          sys_wdata,
  output logic                           sys_wvalid,
  input  logic                           sys_wready,
  input  logic                           sys_grant,
  input  logic                           sys_valid,
  input  logic                           sys_last,
  input  logic [DATA_WIDTH-1:0]          sys_rdata,
  input  logic                           sys_error,
  output logic                           busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]            r_state;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         r_rr_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_we;
  logic [NUM_REQ-1:0]    w_rot;
  logic [IW:0]           w_sum;
  logic [IW-1:0]         w_sel;
  logic [NUM_REQ-1:0]    w_onehot;
  logic                  w_wr;
  logic                  w_end;
  logic                  w_start;
  logic                  w_unused;
  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [LEN_WIDTH-1:0]  w_len   [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_len[g]   = req_len[g*LEN_WIDTH +: LEN_WIDTH];
    assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit of the rotation wins.
  always_comb begin
    w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
    w_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
    w_sel = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : IW'(w_sum);
  end

  assign w_start    = (r_state == S_IDLE) && (|req_valid);
  assign w_end      = (r_state == S_BUSY) && sys_last;
  assign w_wr       = r_we && (r_state != S_IDLE);
  assign w_onehot   = NUM_REQ'(1) << r_owner;
  assign w_unused   = sys_grant;
  assign busy       = r_state != S_IDLE;
  assign sys_req    = r_state == S_ISSUE;
  assign sys_addr   = r_addr;
  assign sys_len    = r_len;
  assign sys_we     = r_we;
  assign sys_wdata  = w_wr ? w_wdata[r_owner] : '0;
  assign sys_wvalid = w_wr && req_wvalid[r_owner];
  assign req_wready = (w_wr && sys_wready) ? w_onehot : '0;
  assign req_accept = sys_req ? w_onehot : '0;
  assign req_rvalid = ((r_state == S_BUSY) && sys_valid) ? w_onehot : '0;
  assign req_done   = w_end ? w_onehot : '0;
  assign req_error  = (w_end && sys_error) ? w_onehot : '0;
  assign req_rdata  = sys_rdata;

  // Command fields are captured at grant so they stay stable through the whole transaction.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_we     <= 1'b0;
    end else if (w_start) begin
      r_state <= S_ISSUE;
      r_owner <= w_sel;
      r_addr  <= w_addr[w_sel];
      r_len   <= w_len[w_sel];
      r_we    <= req_we[w_sel];
    end else if (r_state == S_ISSUE) begin
      r_state  <= S_BUSY;
      r_rr_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
    end else if (w_end) begin
      r_state <= S_IDLE;
    end
  end

`ifdef NAC_ARB_WDOG_EN
  logic [15:0] r_wdog_cnt;
  logic        r_wdog_to;
  assign wdog_timeout = r_wdog_to;
  // Fires once when the count steps onto WDOG_CYCLES, so a clear is not immediately undone.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_wdog_cnt <= '0;
      r_wdog_to  <= 1'b0;
    end else begin
      if (w_start) r_wdog_cnt <= '0;
      else if ((r_state == S_BUSY) && (r_wdog_cnt != '1)) r_wdog_cnt <= r_wdog_cnt + 16'd1;
      if (wdog_clr) r_wdog_to <= 1'b0;
      else if ((r_state == S_BUSY) && (r_wdog_cnt == 16'(WDOG_CYCLES - 1))) r_wdog_to <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_nac_axi_port_arbiter.sv
// tb_nac_axi_port_arbiter: randomized requesters and adapter against a transaction-level round-robin model.
module tb_nac_axi_port_arbiter;
  localparam int N = 4, DW = 32, AW = 32, LW = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_we, req_wvalid, req_wready, req_accept, req_rvalid, req_done, req_error;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] req_rdata, sys_wdata, sys_rdata;
  logic [AW-1:0] sys_addr;
  logic [LW-1:0] sys_len;
  logic sys_req, sys_we, sys_wvalid, sys_wready, sys_grant, sys_valid, sys_last, sys_error, busy;
  logic [AW-1:0] m_addr [N];
  logic [LW-1:0] m_len [N];
  logic [DW-1:0] wd [N];
  logic [N-1:0] m_we, pend, wv;
  int n_cmp = 0, n_bad = 0, ptr = 0;

  always #5 clk = ~clk;
  assign req_valid  = pend;
  assign req_we     = m_we;
  assign req_wvalid = wv;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = m_addr[i];
      req_len[i*LW +: LW]   = m_len[i];
      req_wdata[i*DW +: DW] = wd[i];
    end
  end

  nac_axi_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .req_wvalid(req_wvalid), .req_wready(req_wready), .req_accept(req_accept),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_done(req_done), .req_error(req_error),
    .sys_addr(sys_addr), .sys_len(sys_len), .sys_req(sys_req), .sys_we(sys_we),
    .sys_wdata(sys_wdata), .sys_wvalid(sys_wvalid), .sys_wready(sys_wready), .sys_grant(sys_grant),
    .sys_valid(sys_valid), .sys_last(sys_last), .sys_rdata(sys_rdata), .sys_error(sys_error),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer, wrapping.
  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic new_cmd(input int i, input int we, input int len);
    m_addr[i] = $urandom;
    m_len[i]  = LW'(len);
    m_we[i]   = we[0];
    pend[i]   = 1'b1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sys_req"}, sys_req, 0);
    chk({tag, "_accept"}, req_accept, 0);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_error"}, req_error, 0);
    chk({tag, "_rvalid"}, req_rvalid, 0);
    chk({tag, "_wready"}, req_wready, 0);
    chk({tag, "_sys_wvalid"}, sys_wvalid, 0);
  endtask

  // One transaction: entered in an IDLE cycle with pend already driven; exits in the following IDLE cycle.
  task automatic do_txn(input int exp_w, input int fill);
    int w, beats, cnt, guard;
    logic err, v, lst;
    logic [DW-1:0] rd;
    w = winner();
    cyc();
    sys_valid = 0; sys_error = 0; sys_wready = 0; wv = '0;
    sys_last = 1'($urandom_range(0, 1));
    #1;
    chk("sys_req", sys_req, 1);
    chk("accept", req_accept, 64'(1) << w);
    chk("sys_addr", sys_addr, m_addr[w]);
    chk("sys_len", sys_len, m_len[w]);
    chk("sys_we", sys_we, m_we[w]);
    chk("done_issue", req_done, 0);
    if (exp_w >= 0) chk("rr_order", req_accept, 64'(1) << exp_w);
    pend[w] = 1'b0;
    ptr = (w + 1) % N;
    beats = int'(m_len[w]) + 1; cnt = 0; guard = 0;
    err = ($urandom_range(0, 3) == 0);
    sys_last = 0;
    if (m_we[w]) begin
      while (cnt < beats && guard < 400) begin
        cyc(); guard++;
        for (int i = 0; i < N; i++) wd[i] = $urandom;
        wv = N'($urandom);
        sys_wready = 1'($urandom_range(0, 1));
        #1;
        chk("sys_wdata", sys_wdata, wd[w]);
        chk("sys_wvalid", sys_wvalid, wv[w]);
        chk("req_wready", req_wready, sys_wready ? (64'(1) << w) : 64'(0));
        chk("sys_req_busy", sys_req, 0);
        chk("done_early", req_done, 0);
        if (wv[w] && sys_wready) cnt++;
      end
      cyc();
      wv = '0; sys_wready = 0; sys_last = 1; sys_error = err;
      #1;
      chk("done_wr", req_done, 64'(1) << w);
      chk("error_wr", req_error, 64'(err) << w);
    end else begin
      while (cnt < beats && guard < 400) begin
        cyc(); guard++;
        v = ($urandom_range(0, 3) != 0);
        lst = v && (cnt == beats - 1);
        rd = $urandom;
        sys_valid = v; sys_rdata = rd; sys_last = lst; sys_error = lst & err;
        wv = N'($urandom); sys_wready = 1;
        #1;
        chk("rvalid", req_rvalid, 64'(v) << w);
        chk("rdata", req_rdata, rd);
        chk("done_rd", req_done, 64'(lst) << w);
        chk("error_rd", req_error, 64'(lst & err) << w);
        chk("wready_rd", req_wready, 0);
        chk("sys_wvalid_rd", sys_wvalid, 0);
        if (v) cnt++;
      end
    end
    if (cnt < beats) chk("txn_timeout", cnt, beats);
    cyc();
    sys_valid = 1'($urandom_range(0, 1));
    sys_last = 1'($urandom_range(0, 1));
    sys_error = 1'($urandom_range(0, 1));
    wv = N'($urandom); sys_wready = 1;
    if (fill == 2) begin
      pend = '0;
      new_cmd(1, 1, 7);
    end else begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && (fill == 1 || $urandom_range(0, 1) == 1))
          new_cmd(i, $urandom_range(0, 1), $urandom_range(0, 5));
      if (pend == '0) new_cmd($urandom_range(0, N - 1), $urandom_range(0, 1), $urandom_range(0, 5));
    end
    #1;
    chk_quiet("idle");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_len[i] = '0; wd[i] = '0; end
    m_we = '0; pend = '0; wv = '0;
    sys_wready = 0; sys_grant = 0; sys_valid = 0; sys_last = 0; sys_rdata = '0; sys_error = 0;
    cyc(); #1;
    chk_quiet("reset");
    chk("reset_addr", sys_addr, 0);
    chk("reset_len", sys_len, 0);
    chk("reset_we", sys_we, 0);
    chk("reset_wdata", sys_wdata, 0);
    cyc();
    rst_n = 1;
    for (int i = 0; i < N; i++) new_cmd(i, $urandom_range(0, 1), $urandom_range(0, 5));
    #1;
    chk("idle_busy", busy, 0);
    for (int k = 0; k < 8; k++) do_txn(k % N, 1);
    for (int k = 0; k < 40; k++) do_txn(-1, (k == 39) ? 2 : 0);
    cyc();
    sys_last = 0; sys_valid = 0; wv = '0;
    #1;
    chk("rst_accept", req_accept, 64'(1) << 1);
    pend = '0;
    for (int b = 0; b < 2; b++) begin
      cyc();
      wv = '1; sys_wready = 1; sys_valid = 1; sys_last = 0;
      for (int i = 0; i < N; i++) wd[i] = $urandom;
    end
    #1;
    chk("pre_rst_wvalid", sys_wvalid, 1);
    rst_n = 0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_addr", sys_addr, 0);
    chk("async_rst_len", sys_len, 0);
    chk("async_rst_we", sys_we, 0);
    chk("async_rst_wdata", sys_wdata, 0);
    new_cmd(3, $urandom_range(0, 1), $urandom_range(0, 5));
    wv = '0; sys_wready = 0; sys_valid = 0;
    cyc();
    chk("rst_hold_busy", busy, 0);
    rst_n = 1;
    ptr = 0;
    #1;
    chk("rst_release_busy", busy, 0);
    do_txn(3, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nac_axi_port_arbiter.md
Name: nac_axi_port_arbiter

Overview:
Round-robin arbiter that shares one NAC AXI master adapter command/data port (sys_* interface) between NUM_REQ requesters, e.g. weight fetch, activation fetch, result writeback and descriptor fetch.
- Grants one whole transaction at a time: address phase, all data beats and completion.
- Routes write data, read data and completion/error status to the owning requester.
- Sits between the NAC compute engines and the AXI master adapter, in the M_AXI_ACLK domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, data width; must equal the adapter's C_M_AXI_DATA_WIDTH
ADDR_WIDTH, 32, system address width
LEN_WIDTH, 8, burst length field; 0 means 1 beat

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester command request; held until req_accept
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed command addresses
req_len  in  NUM_REQ*LEN_WIDTH  packed burst lengths
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wvalid  in  NUM_REQ  write data valid
req_wready  out  NUM_REQ  write data ready; owner only
req_accept  out  NUM_REQ  1-cycle pulse: command issued to adapter
req_rvalid  out  NUM_REQ  read beat valid; owner only
req_rdata  out  DATA_WIDTH  read data, broadcast to all requesters
req_done  out  NUM_REQ  1-cycle pulse: transaction complete
req_error  out  NUM_REQ  valid with req_done: AXI error response seen
sys_addr  out  ADDR_WIDTH  to adapter
sys_len  out  LEN_WIDTH  to adapter
sys_req  out  1  to adapter; 1-cycle start strobe
sys_we  out  1  to adapter
sys_wdata  out  DATA_WIDTH  to adapter
sys_wvalid  out  1  to adapter
sys_wready  in  1  from adapter
sys_grant  in  1  from adapter; unused except in debug assertions
sys_valid  in  1  from adapter
sys_last  in  1  from adapter
sys_rdata  in  DATA_WIDTH  from adapter
sys_error  in  1  from adapter
busy  out  1  high outside S_IDLE

Behaviour:
Reset values:
- All outputs 0.
- state = S_IDLE, owner = 0, rr_ptr = 0.

States:
- S_IDLE:
  - If any req_valid is set, choose the first set bit scanning from rr_ptr upward, wrapping at NUM_REQ.
  - Register owner.
  - Register sys_addr/sys_len/sys_we from that requester's fields.
  - Go to S_ISSUE.
- S_ISSUE:
  - sys_req = 1 and req_accept[owner] = 1 for exactly this one cycle.
  - rr_ptr <= owner+1, wrapping NUM_REQ-1 -> 0.
  - Go to S_BUSY.
- S_BUSY:
  - Wait for sys_last = 1.
  - In that cycle: req_done[owner] = 1 and req_error[owner] = sys_error.
  - Go to S_IDLE.

Timing and latency:
- req_valid sampled at edge N gives sys_req and req_accept high during cycle N+1.
- Minimum gap between consecutive sys_req pulses is transaction time + 2 cycles.
  - The gap guarantees the adapter is back in its idle state before the next strobe.

Command and data routing:
- sys_addr/sys_len/sys_we are stable from S_ISSUE until return to S_IDLE.
- Write path is combinational, active only in S_ISSUE/S_BUSY with sys_we = 1:
  - sys_wdata/sys_wvalid = owner's req_wdata/req_wvalid.
  - req_wready[owner] = sys_wready; all other bits 0.
- Read path:
  - req_rvalid[owner] = sys_valid, active only in S_BUSY.
  - req_rdata = sys_rdata, unqualified.

Boundary conditions:
- All requesters asserted continuously: grants rotate 0,1,2,3,0... with no starvation.
- A single requester asserting repeatedly gets back-to-back grants.
- req_valid deasserted before req_accept is illegal; the latched command is still issued.
- sys_last while not in S_BUSY is ignored.
- len = 0 is a 1-beat transaction; done arrives normally.
- Asynchronous reset mid-transaction:
  - Immediately returns to S_IDLE with all outputs 0.
  - The adapter shares the reset.
- Non-owner requesters see req_wready = req_rvalid = req_done = 0 throughout.

Optional Feature:
NAC_ARB_WDOG_EN:
- When defined:
  - Adds parameter WDOG_CYCLES (default 4096) and ports wdog_clr (in, 1) and wdog_timeout (out, 1).
  - A 16-bit counter increments each cycle in S_BUSY and clears on entry to S_ISSUE.
  - When the count reaches WDOG_CYCLES, wdog_timeout sets and stays sticky until wdog_clr or reset.
  - The FSM is not released.
- When undefined: no counter and no extra ports.

Test Plan:
- Single read: req0 read, addr 0x1000, len 3; adapter returns 4 beats 0xA0..0xA3 -> req_accept[0] 1 cycle after req_valid; req_rvalid[0] 4 times with matching data; req_done[0] on the 4th beat; req_error[0] = 0.
- Write with backpressure: req2 write, len 1, data 0x11/0x22; sys_wready toggles 1,0,1 -> both words reach sys_wdata in order; req_wready[0,1,3] stay 0; req_done[2] after sys_last.
- Fairness: req0..3 all held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; the gap between sys_req pulses is never < 2 cycles after sys_last.
- Error: req1 read, adapter asserts sys_error with sys_last -> req_done[1] = req_error[1] = 1 in the same cycle; the next transaction reports req_error = 0.
- Reset mid-burst: drop M_AXI_ARESETN during beat 2 of a len 7 write -> all outputs 0 asynchronously; after release, req3 pending gets a clean grant with sys_req 1 cycle later.
- NAC_ARB_WDOG_EN with WDOG_CYCLES = 100: sys_last withheld -> wdog_timeout rises after 100 S_BUSY cycles; wdog_clr clears it.
